mem2axis_tx: RTL and testbench
==============================

# mem2axis_tx

Streams one completed frame of FFT_SIZE bins out of mem0 onto an AXI4-Stream master. Drives the memory_mux TX-side read port: `axis_tx`, `axis_mem2m_clken`, `axis_mem2m_raddr`, `axis_mem2m_rdata`. Converts the synchronous 1-cycle-latency RAM read into a backpressure-safe stream, with optional bit-reversed address order and `tlast` on the final bin. It is the output-side counterpart to the s2mem writer that fills mem0 during `axis_rx`.

## Interface
- FFT_SIZE, 4096, bins per frame; equals 2**`ADDR_WIDTH`.
- BIT_REVERSE, 0, 1 = read addresses in bit-reversed order of the beat index; 0 = linear order.
- clk  in  1  single clock domain.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  single-cycle pulse that begins one frame; sampled only in IDLE.
- axis_tx  out  1  owns the mem0 port A mux; high from the first read until the last beat is accepted.
- done  out  1  one-cycle pulse after the last beat is accepted.
- axis_mem2m_clken  out  1  mem0 port A enable; the RAM output holds while it is low.
- axis_mem2m_raddr  out  `ADDR_WIDTH`  mem0 read address.
- axis_mem2m_rdata  in  `DATA_WIDTH`  mem0 douta, valid 1 cycle after an enabled read.
- m_axis_tdata  out  `DATA_WIDTH`  driven directly by axis_mem2m_rdata.
- m_axis_tvalid  out  1  beat valid.
- m_axis_tready  in  1  downstream ready.
- m_axis_tlast  out  1  high on beat FFT_SIZE-1 only.

## Operation
- FSM states:
  - IDLE: start → STREAM.
  - STREAM: issues reads until FFT_SIZE addresses have been issued → DRAIN.
  - DRAIN: waits for the handshake of the last beat → DONE.
  - DONE: asserts `done` for one cycle → IDLE.
- `start` outside IDLE is ignored.
- advance = !m_axis_tvalid || m_axis_tready.
- In STREAM:
  - axis_mem2m_clken = advance.
  - On an advance cycle, issue count `icnt` increments.
  - Set pending-valid `vld` and pending-last `lst` for the next cycle.
- In DRAIN:
  - clken = 0, so the last word is held in the RAM output.
  - tvalid clears on the handshake.
- tvalid is registered:
  - On an advance cycle, tvalid ← (a read was issued this cycle).
  - tlast ← (the issued index was FFT_SIZE-1).
- `icnt` width is `ADDR_WIDTH`+1 and counts 0..FFT_SIZE.
- axis_mem2m_raddr = BIT_REVERSE ? bitrev(icnt[`ADDR_WIDTH`-1:0]) : icnt[`ADDR_WIDTH`-1:0].
- `axis_tx` is high in STREAM and DRAIN, and low in IDLE and DONE. It must stay high until the last handshake; dropping it earlier lets memory_mux retarget port A and corrupt douta.
- Data passes through unmodified; no width conversion.
- Reset values: state IDLE; icnt 0; axis_tx, done, clken, tvalid, tlast all 0; raddr 0.
- Reset mid-frame aborts immediately. No partial tlast is emitted. The next `start` restreams from index 0.

## Timing
- Start sampled in cycle S:
  - S+1: axis_tx=1, clken=1, raddr=map(0).
  - S+2: first tvalid, with tdata = mem0[map(0)].
- With tready held high, beat k is valid at S+2+k. The last beat is at S+FFT_SIZE+1.
- `done` is at S+FFT_SIZE+2, and axis_tx falls in the same cycle.
- Throughput is 1 beat/cycle with no bubbles under continuous tready.
- Stall (tvalid && !tready):
  - clken=0, raddr and tdata stable, tlast stable.
  - No beat dropped or duplicated.
  - Resumes on the cycle tready rises.
- tready low at the first beat: tdata holds mem0[map(0)] until accepted.
- The final issue and a stall can coincide: the FSM enters DRAIN only after the final issue, and holds until the handshake.
- A `start` pulse coincident with `done` is ignored; it takes effect only when sampled in IDLE.

## Structure
- Use `ADDR_WIDTH`/`DATA_WIDTH` from fft_defs.vh.
- Add FSM state encodings (IDLE, STREAM, DRAIN, DONE) to fft_defs.vh as `define constants.
- Sub-module `bit_reverse` (parameter WIDTH, purely combinational) is natural and reusable by the FFT address generator.
- No FIFO: the RAM output register plus the clken hold act as the single-entry skid.

## Test plan
- mem0 preloaded with data[a]=a, BIT_REVERSE=0, tready=1 → 4096 beats with tdata 0..4095 in order; tlast only on beat 4095; done at S+4098; axis_tx high for exactly 4097 cycles.
- BIT_REVERSE=1, same preload → beat 1 = 2048, beat 2 = 1024, beat 3 = 3072, beat 4095 = 4095, with tlast on beat 4095.
- Random tready at 50% → a scoreboard matches all 4096 values in order; clken=0 and tdata stable on every stall cycle; no dropped or duplicate beats.
- tready low for 10 cycles at the first valid beat → tdata=0 held for all 10 cycles, then beats resume 1,2,…; the final beat stalled 5 cycles keeps axis_tx=1 until accepted.
- `start` pulsed at beats 100 and 4095 → ignored; exactly one frame and one `done`.
- rst asserted at beat 100 → tvalid, axis_tx and clken go 0 asynchronously; a new `start` yields beat 0 = data[0] at S+2.

Source files
------------

// File: rtl/mem2axis_tx_pkg.sv
// ============================================================================
// Module   : mem2axis_tx_pkg
// Purpose  : Shared widths and FSM state encoding for the mem0 -> AXI4-Stream
//            frame transmitter.
// Contents : ADDR_WIDTH, DATA_WIDTH, state_t
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package mem2axis_tx_pkg;

  // mem0 geometry: one frame of 2**ADDR_WIDTH bins, DATA_WIDTH bits per bin.
  localparam int ADDR_WIDTH = 12;
  localparam int DATA_WIDTH = 32;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1,
    ST_DRAIN  = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

endpackage

`default_nettype wire

// File: rtl/mem2axis_tx_bit_reverse.sv
// ============================================================================
// Module   : bit_reverse
// Purpose  : Purely combinational bit-order reversal of an index; shared by
//            the TX reader and the FFT address generator.
// Ports    : i_addr [WIDTH-1:0]  index in
//            o_addr [WIDTH-1:0]  index with bit order mirrored
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module bit_reverse #(
  parameter int WIDTH = 12
) (
  input  logic [WIDTH-1:0] i_addr,
  output logic [WIDTH-1:0] o_addr
);

  for (genvar g = 0; g < WIDTH; g++) begin : g_bit
    assign o_addr[g] = i_addr[WIDTH-1-g];
  end

endmodule

`default_nettype wire

// File: rtl/mem2axis_tx.sv
// ============================================================================
// Module   : mem2axis_tx
// Purpose  : Streams one completed frame of FFT_SIZE bins out of mem0 onto an
//            AXI4-Stream master, turning the 1-cycle-latency synchronous RAM
//            read into a backpressure-safe stream. The RAM output register,
//            frozen by clken, is the single-entry skid; no FIFO is needed.
// Ports    : clk, rst (async, active high)
//            start              frame start pulse, sampled only in IDLE
//            axis_tx            owns mem0 port A from first read to last beat
//            done               one-cycle pulse after the last handshake
//            axis_mem2m_clken   mem0 port A enable (output holds when low)
//            axis_mem2m_raddr   mem0 read address (linear or bit-reversed)
//            axis_mem2m_rdata   mem0 douta, valid 1 cycle after enabled read
//            m_axis_tdata/tvalid/tready/tlast  AXI4-Stream master
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem2axis_tx
  import mem2axis_tx_pkg::*;
#(
  parameter int FFT_SIZE    = 2 ** ADDR_WIDTH,
  parameter bit BIT_REVERSE = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic                  axis_tx,
  output logic                  done,
  output logic                  axis_mem2m_clken,
  output logic [ADDR_WIDTH-1:0] axis_mem2m_raddr,
  input  logic [DATA_WIDTH-1:0] axis_mem2m_rdata,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tlast
);

  localparam logic [ADDR_WIDTH:0] C_LAST = (ADDR_WIDTH+1)'(FFT_SIZE - 1);
  localparam logic [ADDR_WIDTH:0] C_ONE  = (ADDR_WIDTH+1)'(1);

  state_t                r_state;
  logic [ADDR_WIDTH:0]   r_icnt;
  logic                  r_tvalid;
  logic                  r_tlast;

  logic                  w_advance;
  logic [ADDR_WIDTH-1:0] w_addr_lin;
  logic [ADDR_WIDTH-1:0] w_addr_rev;

  // The output slot can take a new word when it is empty or being consumed.
  assign w_advance  = !r_tvalid || m_axis_tready;
  assign w_addr_lin = r_icnt[ADDR_WIDTH-1:0];

  bit_reverse #(
    .WIDTH (ADDR_WIDTH)
  ) u_bit_reverse (
    .i_addr (w_addr_lin),
    .o_addr (w_addr_rev)
  );

  assign axis_mem2m_raddr = BIT_REVERSE ? w_addr_rev : w_addr_lin;

  // Reads are enabled only while issuing; in DRAIN the RAM output must hold
  // the final word until it is accepted.
  assign axis_mem2m_clken = (r_state == ST_STREAM) && w_advance;

  // Port A ownership spans the whole frame including the final handshake,
  // otherwise memory_mux could retarget the port and corrupt douta.
  assign axis_tx       = (r_state == ST_STREAM) || (r_state == ST_DRAIN);
  assign done          = (r_state == ST_DONE);
  assign m_axis_tdata  = axis_mem2m_rdata;
  assign m_axis_tvalid = r_tvalid;
  assign m_axis_tlast  = r_tlast;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_icnt   <= '0;
      r_tvalid <= 1'b0;
      r_tlast  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_icnt  <= '0;
            r_state <= ST_STREAM;
          end
        end
        ST_STREAM: begin
          // Each advance issues one read; its data appears next cycle,
          // exactly when the registered valid/last describing it do.
          if (w_advance) begin
            r_tvalid <= 1'b1;
            r_tlast  <= (r_icnt == C_LAST);
            r_icnt   <= r_icnt + C_ONE;
            if (r_icnt == C_LAST) begin
              r_state <= ST_DRAIN;
            end
          end
        end
        ST_DRAIN: begin
          // tvalid is always set here, so advance means the last handshake.
          if (w_advance) begin
            r_tvalid <= 1'b0;
            r_tlast  <= 1'b0;
            r_state  <= ST_DONE;
          end
        end
        ST_DONE: begin
          r_icnt  <= '0;
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mem2axis_tx.sv
// ============================================================================
// Module   : tb_mem2axis_tx
// Purpose  : Scoreboard bench for mem2axis_tx: a linear-order instance and a
//            bit-reversed instance, each reading its own model of mem0
//            preloaded with data[a] = a.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem2axis_tx;
  import mem2axis_tx_pkg::*;

  localparam int N = 4096;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] d;
    logic                  l;
  } beat_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  logic                  start_a, tx_a, done_a, clken_a, tvalid_a, tready_a, tlast_a;
  logic [ADDR_WIDTH-1:0] raddr_a;
  logic [DATA_WIDTH-1:0] rdata_a, tdata_a;
  logic                  start_b, tx_b, done_b, clken_b, tvalid_b, tready_b, tlast_b;
  logic [ADDR_WIDTH-1:0] raddr_b;
  logic [DATA_WIDTH-1:0] rdata_b, tdata_b;

  mem2axis_tx #(.FFT_SIZE(N), .BIT_REVERSE(1'b0)) u_dut_a (
    .clk(clk), .rst(rst), .start(start_a), .axis_tx(tx_a), .done(done_a),
    .axis_mem2m_clken(clken_a), .axis_mem2m_raddr(raddr_a),
    .axis_mem2m_rdata(rdata_a), .m_axis_tdata(tdata_a),
    .m_axis_tvalid(tvalid_a), .m_axis_tready(tready_a), .m_axis_tlast(tlast_a));

  mem2axis_tx #(.FFT_SIZE(N), .BIT_REVERSE(1'b1)) u_dut_b (
    .clk(clk), .rst(rst), .start(start_b), .axis_tx(tx_b), .done(done_b),
    .axis_mem2m_clken(clken_b), .axis_mem2m_raddr(raddr_b),
    .axis_mem2m_rdata(rdata_b), .m_axis_tdata(tdata_b),
    .m_axis_tvalid(tvalid_b), .m_axis_tready(tready_b), .m_axis_tlast(tlast_b));

  // mem0 models: synchronous read, output holds while clken is low.
  logic [DATA_WIDTH-1:0] mem [N];
  initial for (int i = 0; i < N; i++) mem[i] = DATA_WIDTH'(i);
  always @(posedge clk) if (clken_a) rdata_a <= mem[raddr_a];
  always @(posedge clk) if (clken_b) rdata_b <= mem[raddr_b];

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [ADDR_WIDTH-1:0] bitrev(input int k);
    logic [ADDR_WIDTH-1:0] v;
    logic [ADDR_WIDTH-1:0] r;
    v = ADDR_WIDTH'(k);
    for (int i = 0; i < ADDR_WIDTH; i++) r[i] = v[ADDR_WIDTH-1-i];
    return r;
  endfunction

  beat_t qa[$];
  beat_t qb[$];
  beat_t e_a, e_b;
  int    hs_a, hs_b, done_cnt_a;
  int    mode;                 // 0: tready=1, 1: random, 2: directed stalls
  int    st1, st2;
  logic  prev_stall_a;
  logic [DATA_WIDTH-1:0] prev_d_a;
  logic  prev_l_a;
  logic [DATA_WIDTH-1:0] bbeat [N];

  // Monitor A: pops the scoreboard on every handshake, checks stall behaviour.
  always @(negedge clk) begin
    if (rst) begin
      prev_stall_a = 1'b0;
    end else begin
      if (done_a) done_cnt_a++;
      if (tvalid_a) chk("tx_high_while_valid", 64'(tx_a), 64'd1);
      if (tvalid_a && !tready_a) begin
        chk("stall_clken", 64'(clken_a), 64'd0);
        if (mode == 2 && hs_a == 0) chk("first_stall_tdata", 64'(tdata_a), 64'd0);
        if (prev_stall_a) begin
          chk("stall_tdata_stable", 64'(tdata_a), 64'(prev_d_a));
          chk("stall_tlast_stable", 64'(tlast_a), 64'(prev_l_a));
        end
        prev_stall_a = 1'b1;
        prev_d_a     = tdata_a;
        prev_l_a     = tlast_a;
      end else begin
        prev_stall_a = 1'b0;
      end
      if (tvalid_a && tready_a) begin
        if (qa.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL extra_beat_a: got tdata %0d expected no beat", tdata_a);
        end else begin
          e_a = qa.pop_front();
          chk("tdata_a", 64'(tdata_a), 64'(e_a.d));
          chk("tlast_a", 64'(tlast_a), 64'(e_a.l));
        end
        hs_a++;
      end
    end
  end

  // Monitor B: bit-reversed instance, tready always high.
  always @(negedge clk) begin
    if (!rst && tvalid_b && tready_b) begin
      if (qb.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL extra_beat_b: got tdata %0d expected no beat", tdata_b);
      end else begin
        e_b = qb.pop_front();
        chk("tdata_b", 64'(tdata_b), 64'(e_b.d));
        chk("tlast_b", 64'(tlast_b), 64'(e_b.l));
      end
      if (hs_b < N) bbeat[hs_b] = tdata_b;
      hs_b++;
    end
  end

  // tready driver for instance A, updated just after each rising edge.
  initial begin
    tready_a = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (mode)
        1: tready_a = 1'($urandom_range(0, 1));
        2: begin
          if (tvalid_a && hs_a == 0 && st1 < 10) begin
            tready_a = 1'b0;
            st1++;
          end else if (tvalid_a && hs_a == N-1 && st2 < 5) begin
            tready_a = 1'b0;
            st2++;
          end else begin
            tready_a = 1'b1;
          end
        end
        default: tready_a = 1'b1;
      endcase
    end
  end

  // One frame on instance A; optionally pulses start at beats 100, N-1 and
  // coincident with done, all of which must be ignored.
  task automatic run_frame_a(input bit inject);
    int n, tx_cyc, d0;
    bit got;
    for (int k = 0; k < N; k++) qa.push_back('{d: DATA_WIDTH'(k), l: (k == N-1)});
    hs_a = 0; st1 = 0; st2 = 0;
    d0 = done_cnt_a;
    @(posedge clk); #1 start_a = 1'b1;
    @(posedge clk); #1 start_a = 1'b0;
    n = 0; tx_cyc = 0; got = 1'b0;
    while (n < 40000 && !got) begin
      @(negedge clk);
      n++;
      if (n == 1) begin
        chk("s1_axis_tx", 64'(tx_a), 64'd1);
        chk("s1_clken", 64'(clken_a), 64'd1);
        chk("s1_raddr", 64'(raddr_a), 64'd0);
      end
      if (n == 2) begin
        chk("s2_tvalid", 64'(tvalid_a), 64'd1);
        chk("s2_tdata", 64'(tdata_a), 64'd0);
      end
      if (tx_a) tx_cyc++;
      start_a = inject && ((tvalid_a && (hs_a == 100 || hs_a == N-1)) || done_a);
      if (done_a) got = 1'b1;
    end
    if (!got) begin
      n_cmp++;
      n_bad++;
      $display("FAIL done_timeout_a: got no done expected done within 40000 cycles");
    end
    @(posedge clk); #1 start_a = 1'b0;
    if (mode == 0) begin
      chk("done_cycle", 64'(n), 64'(N + 2));
      chk("tx_cycles", 64'(tx_cyc), 64'(N + 1));
    end
    repeat (20) @(posedge clk);
    @(negedge clk);
    chk("beats_accepted", 64'(hs_a), 64'(N));
    chk("queue_empty", 64'(qa.size()), 64'd0);
    chk("done_count", 64'(done_cnt_a - d0), 64'd1);
    chk("idle_axis_tx", 64'(tx_a), 64'd0);
    qa.delete();
  endtask

  initial begin
    int n;
    bit got;
    rst = 1'b1; start_a = 1'b0; start_b = 1'b0; tready_b = 1'b1;
    mode = 0; hs_a = 0; hs_b = 0; done_cnt_a = 0; st1 = 0; st2 = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_tvalid", 64'(tvalid_a), 64'd0);
    chk("rst_tlast", 64'(tlast_a), 64'd0);
    chk("rst_axis_tx", 64'(tx_a), 64'd0);
    chk("rst_done", 64'(done_a), 64'd0);
    chk("rst_clken", 64'(clken_a), 64'd0);
    chk("rst_raddr", 64'(raddr_a), 64'd0);
    @(posedge clk); #1 rst = 1'b0;

    // Linear order, continuous tready.
    mode = 0;
    run_frame_a(1'b0);

    // Bit-reversed order on instance B.
    for (int k = 0; k < N; k++) qb.push_back('{d: DATA_WIDTH'(bitrev(k)), l: (k == N-1)});
    hs_b = 0;
    @(posedge clk); #1 start_b = 1'b1;
    @(posedge clk); #1 start_b = 1'b0;
    n = 0; got = 1'b0;
    while (n < 10000 && !got) begin
      @(negedge clk);
      n++;
      if (done_b) got = 1'b1;
    end
    chk("b_done_cycle", 64'(n), 64'(N + 2));
    chk("b_beats", 64'(hs_b), 64'(N));
    chk("b_queue_empty", 64'(qb.size()), 64'd0);
    chk("b_beat1", 64'(bbeat[1]), 64'd2048);
    chk("b_beat2", 64'(bbeat[2]), 64'd1024);
    chk("b_beat3", 64'(bbeat[3]), 64'd3072);
    chk("b_beat4095", 64'(bbeat[N-1]), 64'd4095);

    // Random 50% backpressure.
    mode = 1;
    run_frame_a(1'b0);

    // 10-cycle stall on the first beat, 5-cycle stall on the last.
    mode = 2;
    run_frame_a(1'b0);
    chk("first_stall_len", 64'(st1), 64'd10);
    chk("last_stall_len", 64'(st2), 64'd5);

    // Stray start pulses mid-frame, at the last beat and with done.
    mode = 0;
    run_frame_a(1'b1);

    // Asynchronous reset mid-frame, then a clean frame.
    for (int k = 0; k < N; k++) qa.push_back('{d: DATA_WIDTH'(k), l: (k == N-1)});
    hs_a = 0;
    @(posedge clk); #1 start_a = 1'b1;
    @(posedge clk); #1 start_a = 1'b0;
    n = 0;
    while (n < 1000 && hs_a < 100) begin
      @(negedge clk);
      n++;
    end
    chk("reached_beat100", 64'(hs_a), 64'd100);
    #2 rst = 1'b1;
    #1;
    chk("arst_tvalid", 64'(tvalid_a), 64'd0);
    chk("arst_axis_tx", 64'(tx_a), 64'd0);
    chk("arst_clken", 64'(clken_a), 64'd0);
    chk("arst_tlast", 64'(tlast_a), 64'd0);
    qa.delete();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    run_frame_a(1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
